// File: rtl/pipe321_unpipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Definitions shared by the "add 1, add 2, add 3" forward byte pipe and its
// inverse, pipe321_unpipe. Keeping both sets of constants here means the two
// ends of the chain cannot drift apart.
//   maybe_byte_t : {v, d}. A valid tag plus an 8-bit payload.
//   UNPIPE_K*    : constants subtracted by the inverse stages 1..3.
//   FWD_K*       : constants added by the forward stages 1..3.
//   CNT_WIDTH    : width of the optional transfer counter.
//   sat_inc      : saturating increment used by the transfer counter.
// -----------------------------------------------------------------------------
package pipe_pkg;

   localparam int DATA_WIDTH = 8;

   // Inverse pipe: subtract 3, then 2, then 1.
   localparam int UNPIPE_K1 = 3;
   localparam int UNPIPE_K2 = 2;
   localparam int UNPIPE_K3 = 1;

   // Forward pipe: add 1, then 2, then 3.
   localparam int FWD_K1 = 1;
   localparam int FWD_K2 = 2;
   localparam int FWD_K3 = 3;

   localparam int CNT_WIDTH = 16;

   typedef struct packed {
      logic                  v;
      logic [DATA_WIDTH-1:0] d;
   } maybe_byte_t;

   // Counts up and sticks at all-ones. It never wraps back to zero.
   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
      return (c == '1) ? c : c + CNT_WIDTH'(1);
   endfunction

endpackage

// File: rtl/pipe321_unpipe_if.sv
// -----------------------------------------------------------------------------
// pipe321_unpipe_if
// Ready/valid Maybe-stream link. The pipe uses it for its upstream side, its
// downstream side, and the links between stages.
//   v     : valid (Maybe tag, 1 = Just)
//   d     : payload, WIDTH bits; only meaningful while v = 1
//   ready : consumer can take an item this cycle
// Modports:
//   master : producer side; drives v/d, observes ready
//   slave  : consumer side; observes v/d, drives ready
// -----------------------------------------------------------------------------
interface pipe321_unpipe_if #(
   parameter int WIDTH = 8
);
   logic             v;
   logic [WIDTH-1:0] d;
   logic             ready;

   modport master (output v, output d, input  ready);
   modport slave  (input  v, input  d, output ready);
endinterface

// File: rtl/pipe321_unpipe_sub_stage.sv
// -----------------------------------------------------------------------------
// pipe_sub_stage
// A single registered Maybe stage that subtracts the constant K, modulo
// 2^WIDTH. The stage loads whenever it is empty or downstream is ready. An
// empty stage therefore always refills, and bubbles squeeze out while the
// output is stalled.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   up       : slave link; up.ready is this stage's advance signal
//   dn       : master link; dn.v/dn.d are the stage register, and dn.ready
//              is the advance signal of the next stage
// -----------------------------------------------------------------------------
module pipe_sub_stage
   import pipe_pkg::*;
#(
   parameter int WIDTH = DATA_WIDTH,
   parameter int K     = 1
) (
   input  logic            clk,
   input  logic            rst,
   pipe321_unpipe_if.slave  up,
   pipe321_unpipe_if.master dn
);

   localparam logic [WIDTH-1:0] KW = WIDTH'(K);

   logic adv;

   // The stage can take a new item if it is empty, or if its current item
   // leaves this cycle.
   assign adv      = ~dn.v | dn.ready;
   assign up.ready = adv;

   // NOTE: stage registers use non-blocking assignments and the async reset
   // clears both the tag and the payload, so the pipe empties immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dn.v <= 1'b0;
         dn.d <= '0;
      end else if (adv) begin
         dn.v <= up.v;
         dn.d <= up.d - KW;
      end
   end

endmodule

// File: rtl/pipe321_unpipe.sv
// -----------------------------------------------------------------------------
// pipe321_unpipe
// Inverse of the three-stage "+1, +2, +3" byte pipe. It subtracts 3, then 2,
// then 1, in three registered stages, and adds ready/valid back-pressure.
// When fed directly from the forward pipe, the chain returns every payload
// byte unchanged.
// Ports:
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset
//   __in0   : upstream valid
//   __in1   : upstream payload (ignored while __in0 = 0)
//   __in2   : downstream ready
//   __out0  : downstream valid
//   __out1  : downstream payload, forced to 0 while __out0 = 0
//   __out2  : upstream ready (combinational from stage state and __in2)
//   __out3  : saturating count of downstream transfers, 16 bits
//             (present only when PIPE321_UNPIPE_COUNT_EN is defined)
// Optional feature macro: PIPE321_UNPIPE_COUNT_EN
// -----------------------------------------------------------------------------
module pipe321_unpipe
   import pipe_pkg::*;
#(
   parameter int WIDTH = DATA_WIDTH,
   parameter int K1    = UNPIPE_K1,
   parameter int K2    = UNPIPE_K2,
   parameter int K3    = UNPIPE_K3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             __in0,
   input  logic [WIDTH-1:0] __in1,
   input  logic             __in2,
   output logic             __out0,
   output logic [WIDTH-1:0] __out1,
   output logic             __out2
`ifdef PIPE321_UNPIPE_COUNT_EN
   ,
   output logic [CNT_WIDTH-1:0] __out3
`endif
);

   // link_0: upstream input. link_1/link_2: between stages. link_3: s3 output.
   pipe321_unpipe_if #(.WIDTH(WIDTH)) link_0 ();
   pipe321_unpipe_if #(.WIDTH(WIDTH)) link_1 ();
   pipe321_unpipe_if #(.WIDTH(WIDTH)) link_2 ();
   pipe321_unpipe_if #(.WIDTH(WIDTH)) link_3 ();

   assign link_0.v     = __in0;
   assign link_0.d     = __in1;
   assign __out2       = link_0.ready;   // adv1
   assign link_3.ready = __in2;          // drives adv3 = ~s3.v | __in2

   pipe_sub_stage #(.WIDTH(WIDTH), .K(K1)) u_stage_1 (
      .clk (clk),
      .rst (rst),
      .up  (link_0),
      .dn  (link_1)
   );

   pipe_sub_stage #(.WIDTH(WIDTH), .K(K2)) u_stage_2 (
      .clk (clk),
      .rst (rst),
      .up  (link_1),
      .dn  (link_2)
   );

   pipe_sub_stage #(.WIDTH(WIDTH), .K(K3)) u_stage_3 (
      .clk (clk),
      .rst (rst),
      .up  (link_2),
      .dn  (link_3)
   );

   assign __out0 = link_3.v;
   // Mask the payload so that a stale or garbage register value never shows
   // while the output is empty.
   assign __out1 = link_3.v ? link_3.d : '0;

`ifdef PIPE321_UNPIPE_COUNT_EN
   logic [CNT_WIDTH-1:0] xfer_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         xfer_cnt <= '0;
      end else if (__out0 && __in2) begin
         xfer_cnt <= sat_inc(xfer_cnt);
      end
   end

   assign __out3 = xfer_cnt;
`endif

endmodule

// File: tb/tb_pipe321_unpipe.sv
// -----------------------------------------------------------------------------
// tb_pipe321_unpipe
// Self-checking bench for pipe321_unpipe. Directed sequences cover latency,
// wrap-around, streaming, stall/fill, and mid-stream reset. A scoreboard
// queue holds the expected output bytes. A forward "+1,+2,+3" model then
// drives a random round trip through the block.
// Optional feature macro: PIPE321_UNPIPE_COUNT_EN
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pipe321_unpipe;
   import pipe_pkg::*;

   logic       clk;
   logic       rst;
   logic       drv_v;
   logic [7:0] drv_d;
   logic       drv_rdy;
   logic       rt_mode;
   logic       out0;
   logic [7:0] out1;
   logic       out2;
`ifdef PIPE321_UNPIPE_COUNT_EN
   logic [15:0] cnt;
`endif

   int errors = 0;
   int checks = 0;

   logic [7:0] exp_q[$];
   int         n_deliv;
   logic       hold_valid;
   logic [7:0] hold_val;

   maybe_byte_t f1, f2, f3;   // forward pipe stages

   pipe321_unpipe_if #(.WIDTH(8)) up_bus ();

   assign up_bus.v     = rt_mode ? f3.v : drv_v;
   assign up_bus.d     = rt_mode ? f3.d : drv_d;
   assign up_bus.ready = out2;

   pipe321_unpipe dut (
      .clk    (clk),
      .rst    (rst),
      .__in0  (up_bus.v),
      .__in1  (up_bus.d),
      .__in2  (drv_rdy),
      .__out0 (out0),
      .__out1 (out1),
`ifdef PIPE321_UNPIPE_COUNT_EN
      .__out3 (cnt),
`endif
      .__out2 (out2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Forward "+1, +2, +3" pipe with no back-pressure. It feeds the DUT in
   // round-trip mode.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         f1 <= '0;
         f2 <= '0;
         f3 <= '0;
      end else begin
         f1.v <= drv_v;
         f1.d <= drv_d + 8'(FWD_K1);
         f2.v <= f1.v;
         f2.d <= f1.d + 8'(FWD_K2);
         f3.v <= f2.v;
         f3.d <= f2.d + 8'(FWD_K3);
      end
   end

   // Monitor and scoreboard, sampled mid-cycle on the falling edge.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         hold_valid = 1'b0;
         n_deliv    = 0;
      end else begin
         if (up_bus.v && out2 && !rt_mode)
            exp_q.push_back(up_bus.d - 8'd6);
         if (rt_mode && up_bus.v)
            check("rt_ready", out2, 1);
         if (!out0)
            check("idle_zero", out1, 0);
         if (hold_valid) begin
            check("held_valid", out0, 1);
            check("held_data", out1, hold_val);
         end
         if (out0 && drv_rdy) begin
            check("sb_nonempty", (exp_q.size() > 0), 1);
            if (exp_q.size() > 0)
               check("sb_data", out1, exp_q.pop_front());
            n_deliv++;
         end
         hold_valid = out0 && !drv_rdy;
         hold_val   = out1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [7:0] d);
      drv_v = v;
      drv_d = d;
   endtask

   task automatic idle(input int n);
      drv_v = 1'b0;
      repeat (n) begin
         drv_d = 8'($urandom);
         tick();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      int stale;
      int gap;
      logic [7:0] b;

      rst     = 1'b1;
      rt_mode = 1'b0;
      drv_rdy = 1'b1;
      drive(1'b0, 8'h00);
      #1;
      check("rst_out0", out0, 0);
      check("rst_out1", out1, 0);
      check("rst_out2", out2, 1);
`ifdef PIPE321_UNPIPE_COUNT_EN
      check("rst_cnt", cnt, 0);
`endif
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      tick();

      // Single accept: valid output exactly three cycles later, for one cycle.
      drive(1'b1, 8'h07);
      @(negedge clk);
      check("t1_acc", out2, 1);
      tick();
      drive(1'b0, 8'($urandom));
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         check("t1_lat", out0, (i == 3));
      end
      idle(2);

      // Wrap-around: 0x02 -> 0xFC, 0x00 -> 0xFA.
      drive(1'b1, 8'h02);
      tick();
      drive(1'b1, 8'h00);
      tick();
      idle(6);

      // Back-to-back stream with no stall.
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 8'(8'h10 + k));
         @(negedge clk);
         check("t3_rdy", out2, 1);
         tick();
      end
      drive(1'b0, 8'($urandom));
      for (int i = 3; i <= 6; i++) begin
         @(negedge clk);
         check("t3_stream", out0, (i <= 5));
      end
      idle(2);

      // Stall and fill, then release with a same-cycle pop and push.
      d0      = n_deliv;
      drv_rdy = 1'b0;
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 8'(8'h20 + k));
         @(negedge clk);
         check("t4_acc", out2, 1);
         tick();
      end
      drive(1'b1, 8'h23);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("t4_full", out2, 0);
         check("t4_head", out1, 8'h1A);
         tick();
      end
      drv_rdy = 1'b1;
      @(negedge clk);
      check("t4_popush", out2, 1);
      tick();
      drive(1'b1, 8'h24);
      @(negedge clk);
      check("t4_acc5", out2, 1);
      tick();
      idle(8);
      check("t4_drain", exp_q.size(), 0);
      check("t4_count", n_deliv - d0, 5);

      // Reset asserted with three items in flight.
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 8'(8'h30 + k));
         tick();
      end
      drive(1'b0, 8'($urandom));
      drv_rdy = 1'b0;
      check("t5_pre", out0, 1);
      #1 rst = 1'b1;
      #1;
      check("t5_out0", out0, 0);
      check("t5_out1", out1, 0);
      check("t5_out2", out2, 1);
`ifdef PIPE321_UNPIPE_COUNT_EN
      check("t5_cnt", cnt, 0);
`endif
      @(posedge clk);
      #2 rst = 1'b0;
      drv_rdy = 1'b1;
      stale   = 0;
      repeat (6) begin
         @(negedge clk);
         if (out0) stale++;
      end
      check("t5_stale", stale, 0);
      tick();

      // Round trip: forward pipe into this block, random bytes and gaps.
      rst     = 1'b1;
      rt_mode = 1'b1;
      drv_rdy = 1'b1;
      drive(1'b0, 8'h00);
      tick();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 40; i++) begin
         b = 8'($urandom);
         drive(1'b1, b);
         exp_q.push_back(b);
         tick();
         gap = $urandom_range(0, 2);
         drive(1'b0, 8'($urandom));
         repeat (gap) tick();
      end
      idle(10);
      check("rt_drain", exp_q.size(), 0);
      check("rt_count", n_deliv, 40);
`ifdef PIPE321_UNPIPE_COUNT_EN
      check("rt_cnt", cnt, n_deliv);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
